group_digit_checker: RTL and testbench
======================================

GROUP_DIGIT_CHECKER -- requirements
Module: group_digit_checker

Interface
REQ-001 SHALL provide parameter N, default 4, meaning digits per Sudoku group (row/column/box); legal range 1..15.
REQ-002 SHALL provide parameter DW, default 4, meaning digit width in bits; fixed at 4, and any other value is unsupported.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port start  input  1  begins a new group; clears all accumulated state.
REQ-006 SHALL have port in_valid  input  1  digit presented this cycle.
REQ-007 SHALL have port digit  input  DW  cell value; 0 = blank, 1..N = digit, >N = illegal.
REQ-008 SHALL have port in_ready  output  1  block accepts a digit this cycle.
REQ-009 SHALL have port busy  output  1  high in COLLECT state.
REQ-010 SHALL have port done  output  1  one-cycle pulse when group evaluation completes.
REQ-011 SHALL have port ok  output  1  group complete and legal; valid when done=1 and held until next start.
REQ-012 SHALL have port dup_err  output  1  a digit 1..N was seen twice in the current group.
REQ-013 SHALL have port range_err  output  1  a digit >N was accepted in the current group.
REQ-014 SHALL have port seen_mask  output  N  one-hot accumulation; bit k set when digit k+1 accepted.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DONE.
REQ-016 IDLE: in_ready=0; start=1 -> COLLECT next cycle with seen_mask, count, dup_err, range_err cleared.
REQ-017 COLLECT: in_ready=1; a digit is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-018 Accepted digit d in 1..N SHALL set seen_mask[d-1] on the next edge; if that bit was already set, dup_err SHALL set (sticky).
REQ-019 Accepted digit 0 SHALL change no mask bit; accepted d>N SHALL set range_err (sticky) and change no mask bit.
REQ-020 Every accepted digit SHALL increment a count register of width $clog2(N+1), regardless of value.
REQ-021 Acceptance that brings count to N SHALL move to DONE on the same edge; done=1 in exactly that next cycle.
REQ-022 DONE: in_ready=0, done=1, ok = (seen_mask all ones) AND NOT dup_err AND NOT range_err; next state IDLE.
REQ-023 ok, dup_err, range_err, seen_mask SHALL hold their values in IDLE until the next start.
REQ-024 start=1 in COLLECT SHALL abort the group: clear state and remain in COLLECT; a digit offered that cycle is discarded.
REQ-025 start=1 in DONE SHALL enter COLLECT cleared; done still pulses that cycle with the finished group's ok.
REQ-026 in_valid in IDLE or DONE SHALL be ignored with no state change.
REQ-027 ok SHALL be 0 whenever state is not DONE and no group has completed since the last start/reset.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, count=0, seen_mask=0, ok=0, dup_err=0, range_err=0, done=0, busy=0, in_ready=0.
REQ-029 Reset SHALL take priority over start and in_valid, including mid-COLLECT; a partial group is discarded and no done pulse follows.

Configuration
REQ-030 Macro GROUP_CHK_MISSING_EN defined: extra output missing_mask (N bits) = ~seen_mask, registered, reset 0, cleared to 0 on start, updated each accept.
REQ-031 Macro GROUP_CHK_MISSING_EN undefined: port missing_mask absent; all other behaviour identical.

Verification
REQ-032 N=4, start, digits 1,2,3,4 back-to-back -> done 1 cycle after 4th accept, ok=1, seen_mask=4'b1111, dup_err=0.
REQ-033 N=4, digits 2,0,4,1 -> ok=0, seen_mask=4'b1011, dup_err=0, range_err=0; missing_mask=4'b0100 when macro defined.
REQ-034 N=4, digits 3,3,1,2 -> dup_err set after 2nd accept, ok=0, seen_mask=4'b0111.
REQ-035 N=4, digits 1,5,2,3 -> range_err=1, ok=0, seen_mask=4'b0111.
REQ-036 N=4, two digits accepted then start -> state cleared, 4 further digits 4,3,2,1 -> ok=1; then rst_n=0 mid-group -> all outputs 0, no done.
REQ-037 N=9, digits 1..9 with in_valid gaps -> done only after 9th accept, ok=1, seen_mask=9'h1FF.

Source files
------------

// File: rtl/group_digit_checker.sv
// Sudoku group checker: collects N digits, flags duplicates and out-of-range values, reports ok.
// Optional GROUP_CHK_MISSING_EN adds a registered missing_mask output (~seen_mask).
module group_digit_checker #(
  parameter int N  = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] digit,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          ok,
  output logic          dup_err,
  output logic          range_err,
  output logic [N-1:0]  seen_mask
`ifdef GROUP_CHK_MISSING_EN
  ,
  output logic [N-1:0]  missing_mask
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} stateT;

  stateT          state;
  logic [CW-1:0]  count;
  logic           accept;
  logic           inDigit;
  logic           overRange;
  logic           lastAccept;
  logic [N-1:0]   hit;
  logic [N-1:0]   nextMask;
  logic           nextDup;
  logic           nextRange;
  logic           nextOk;

  always_comb begin
    accept     = (state == COLLECT) && in_valid && !start;
    inDigit    = (digit != '0) && (digit <= DW'(N));
    overRange  = digit > DW'(N);
    hit        = inDigit ? (N'(1) << (digit - DW'(1))) : '0;
    nextMask   = seen_mask | hit;
    nextDup    = dup_err | (|(seen_mask & hit));
    nextRange  = range_err | overRange;
    nextOk     = (&nextMask) && !nextDup && !nextRange;
    lastAccept = accept && (count == CW'(N - 1));
  end

  // start is handled ahead of the state case: it means "clear and collect" from every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      seen_mask <= '0;
      ok        <= 1'b0;
      dup_err   <= 1'b0;
      range_err <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef GROUP_CHK_MISSING_EN
      missing_mask <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state     <= COLLECT;
        count     <= '0;
        seen_mask <= '0;
        ok        <= 1'b0;
        dup_err   <= 1'b0;
        range_err <= 1'b0;
        busy      <= 1'b1;
        in_ready  <= 1'b1;
`ifdef GROUP_CHK_MISSING_EN
        missing_mask <= '0;
`endif
      end else begin
        case (state)
          COLLECT: begin
            if (accept) begin
              count     <= count + CW'(1);
              seen_mask <= nextMask;
              dup_err   <= nextDup;
              range_err <= nextRange;
`ifdef GROUP_CHK_MISSING_EN
              missing_mask <= ~nextMask;
`endif
              if (lastAccept) begin
                state    <= DONE;
                done     <= 1'b1;
                ok       <= nextOk;
                busy     <= 1'b0;
                in_ready <= 1'b0;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_group_digit_checker.sv
// Self-checking bench for group_digit_checker (N=4 and N=9 instances) against a digit-count model.
module tb_group_digit_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       inValid = 1'b0;
  logic [3:0] digit = '0;

  logic       rdy4, busy4, done4, ok4, dup4, rng4;
  logic [3:0] mask4;
  logic       rdy9, busy9, done9, ok9, dup9, rng9;
  logic [8:0] mask9;
`ifdef GROUP_CHK_MISSING_EN
  logic [3:0] miss4;
  logic [8:0] miss9;
`endif

  int checks = 0;
  int errors = 0;
  bit big = 1'b0;
  int gN = 4;
  int cnt[16];
  int accepted;
  bit rangeSeen;
  int q[$];

  always #5 clk = ~clk;

  group_digit_checker #(.N(4), .DW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid), .digit(digit),
    .in_ready(rdy4), .busy(busy4), .done(done4), .ok(ok4), .dup_err(dup4),
    .range_err(rng4), .seen_mask(mask4)
`ifdef GROUP_CHK_MISSING_EN
    , .missing_mask(miss4)
`endif
  );

  group_digit_checker #(.N(9), .DW(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid), .digit(digit),
    .in_ready(rdy9), .busy(busy9), .done(done9), .ok(ok9), .dup_err(dup9),
    .range_err(rng9), .seen_mask(mask9)
`ifdef GROUP_CHK_MISSING_EN
    , .missing_mask(miss9)
`endif
  );

  logic        oRdy, oBusy, oDone, oOk, oDup, oRng;
  logic [15:0] oMask;
  assign oRdy  = big ? rdy9  : rdy4;
  assign oBusy = big ? busy9 : busy4;
  assign oDone = big ? done9 : done4;
  assign oOk   = big ? ok9   : ok4;
  assign oDup  = big ? dup9  : dup4;
  assign oRng  = big ? rng9  : rng4;
  assign oMask = big ? {7'b0, mask9} : {12'b0, mask4};
`ifdef GROUP_CHK_MISSING_EN
  logic [15:0] oMiss;
  assign oMiss = big ? {7'b0, miss9} : {12'b0, miss4};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fullMask();
    return 16'((32'd1 << gN) - 1);
  endfunction

  function automatic logic [15:0] expMask();
    logic [15:0] m = '0;
    for (int k = 1; k <= gN; k++)
      if (cnt[k] > 0) m[k-1] = 1'b1;
    return m;
  endfunction

  function automatic logic expDup();
    for (int k = 1; k <= gN; k++)
      if (cnt[k] > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic expOk();
    return (expMask() == fullMask()) && !expDup() && !rangeSeen;
  endfunction

  task automatic clearModel();
    foreach (cnt[i]) cnt[i] = 0;
    accepted  = 0;
    rangeSeen = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    check({tag, ".busy"}, 32'(oBusy), 32'd1);
    check({tag, ".rdy"},  32'(oRdy),  32'd1);
    check({tag, ".mask"}, 32'(oMask), 32'd0);
    check({tag, ".dup"},  32'(oDup),  32'd0);
    check({tag, ".rng"},  32'(oRng),  32'd0);
    check({tag, ".ok"},   32'(oOk),   32'd0);
`ifdef GROUP_CHK_MISSING_EN
    check({tag, ".miss"}, 32'(oMiss), 32'd0);
`endif
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".busy"}, 32'(oBusy), 32'd0);
    check({tag, ".rdy"},  32'(oRdy),  32'd0);
    check({tag, ".done"}, 32'(oDone), 32'd0);
    check({tag, ".ok"},   32'(oOk),   32'd0);
    check({tag, ".mask"}, 32'(oMask), 32'd0);
    check({tag, ".dup"},  32'(oDup),  32'd0);
    check({tag, ".rng"},  32'(oRng),  32'd0);
`ifdef GROUP_CHK_MISSING_EN
    check({tag, ".miss"}, 32'(oMiss), 32'd0);
`endif
  endtask

  task automatic beginGroup(input bit useBig);
    big = useBig;
    gN  = useBig ? 9 : 4;
    start = 1'b1;
    inValid = 1'b0;
    step();
    start = 1'b0;
    clearModel();
    checkCleared("start");
  endtask

  task automatic offer(input int d, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        check("gapDone", 32'(oDone), 32'd0);
      end
    end
    inValid = 1'b1;
    digit = d[3:0];
    step();
    inValid = 1'b0;
    accepted++;
    if (d >= 1 && d <= gN) cnt[d]++;
    else if (d > gN) rangeSeen = 1'b1;
    check("mask", 32'(oMask), 32'(expMask()));
    check("dup",  32'(oDup),  32'(expDup()));
    check("rng",  32'(oRng),  32'(rangeSeen));
`ifdef GROUP_CHK_MISSING_EN
    check("miss", 32'(oMiss), 32'(~expMask() & fullMask()));
`endif
    if (accepted == gN) begin
      check("doneLast", 32'(oDone), 32'd1);
      check("okLast",   32'(oOk),   32'(expOk()));
      check("rdyDone",  32'(oRdy),  32'd0);
      check("busyDone", 32'(oBusy), 32'd0);
    end else begin
      check("doneMid", 32'(oDone), 32'd0);
      check("okMid",   32'(oOk),   32'd0);
      check("rdyMid",  32'(oRdy),  32'd1);
    end
  endtask

  task automatic finishIdle();
    step();
    check("idleDone", 32'(oDone), 32'd0);
    check("idleOk",   32'(oOk),   32'(expOk()));
    check("idleBusy", 32'(oBusy), 32'd0);
    inValid = 1'b1;
    digit = 4'($urandom_range(1, 4));
    step();
    inValid = 1'b0;
    check("idleIgnMask", 32'(oMask), 32'(expMask()));
    check("idleIgnOk",   32'(oOk),   32'(expOk()));
    check("idleIgnDone", 32'(oDone), 32'd0);
  endtask

  task automatic runGroup(input bit useBig, input bit gaps);
    beginGroup(useBig);
    foreach (q[i]) offer(q[i], gaps);
    finishIdle();
  endtask

  initial begin
    clearModel();
    step();
    step();
    checkZero("reset4");
    check("reset9.mask", 32'(mask9), 32'd0);
    check("reset9.ok",   32'(ok9),   32'd0);
    rst_n = 1'b1;
    step();
    check("idleRdy", 32'(oRdy), 32'd0);

    q = '{1, 2, 3, 4}; runGroup(1'b0, 1'b0);
    q = '{2, 0, 4, 1}; runGroup(1'b0, 1'b0);
    q = '{3, 3, 1, 2}; runGroup(1'b0, 1'b0);
    q = '{1, 5, 2, 3}; runGroup(1'b0, 1'b0);

    // abort mid-group: digit offered with start is discarded
    beginGroup(1'b0);
    offer(1, 1'b0);
    offer(2, 1'b0);
    start = 1'b1; inValid = 1'b1; digit = 4'd3;
    step();
    start = 1'b0; inValid = 1'b0;
    clearModel();
    checkCleared("abort");
    offer(4, 1'b0); offer(3, 1'b0); offer(2, 1'b0); offer(1, 1'b0);
    finishIdle();

    // start while in DONE
    beginGroup(1'b0);
    offer(4, 1'b0); offer(2, 1'b0); offer(3, 1'b0); offer(1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    clearModel();
    checkCleared("startInDone");
    check("startInDone.done", 32'(oDone), 32'd0);
    for (int i = 0; i < 4; i++) offer(int'($urandom_range(0, 5)), 1'b1);
    finishIdle();

    // reset mid-group
    beginGroup(1'b0);
    offer(2, 1'b0);
    offer(1, 1'b0);
    rst_n = 1'b0;
    step();
    checkZero("midReset");
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("postResetDone", 32'(oDone), 32'd0);
      check("postResetBusy", 32'(oBusy), 32'd0);
    end

    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; runGroup(1'b1, 1'b1);
    check("n9.mask", 32'(mask9), 32'h1FF);

    for (int g = 0; g < 30; g++) begin
      bit useBig;
      int n;
      useBig = 1'($urandom_range(0, 1));
      n = useBig ? 9 : 4;
      q = {};
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 1; k <= n; k++) q.push_back(k);
        for (int k = n - 1; k > 0; k--) begin
          int j, t;
          j = int'($urandom_range(0, k));
          t = q[k]; q[k] = q[j]; q[j] = t;
        end
      end else begin
        for (int k = 0; k < n; k++) q.push_back(int'($urandom_range(0, n + 2)));
      end
      runGroup(useBig, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
